// File: rtl/check_scheduler.sv
// Round-robin result-check scheduler: arbitrates requesters, compares
// expected vs actual words/widths, and keeps registered pass/fail statistics.
module check_scheduler #(
    parameter int WORD   = 64,
    parameter int NREQ   = 4,
    parameter int BITS_W = 7,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     finish,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WORD-1:0]     er,
    input  logic [NREQ*WORD-1:0]     ar,
    input  logic [NREQ*BITS_W-1:0]   er_bits,
    input  logic [NREQ*BITS_W-1:0]   ar_bits,
    output logic [NREQ-1:0]          gnt,
    output logic                     result_valid,
    output logic                     result_pass,
    output logic [2:0]               result_src,
    output logic [CNT_W-1:0]         result_step,
    output logic [CNT_W-1:0]         pass_count,
    output logic [CNT_W-1:0]         fail_count,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  w_idx;
    logic              w_any;
    logic              w_clear;
    logic              w_pass;
    logic [CNT_W-1:0]  r_step;
    logic [CNT_W-1:0]  r_pass_cnt;
    logic [CNT_W-1:0]  r_fail_cnt;
    logic [CNT_W-1:0]  r_res_step;
    logic              r_valid;
    logic              r_pass;
    logic [2:0]        r_src;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ)
            s = s - NREQ;
        return IDX_W'(s);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // NOTE: every signal driven in always_comb gets a default first, so no latch can form.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next = S_RUN;
            S_RUN:   if (finish) w_next = S_DONE;
            S_DONE:  if (start)  w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state == S_RUN);
        done    = (r_state == S_DONE);
        w_clear = start && (r_state != S_RUN);
    end

    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        w_idx = '0;
        gnt   = '0;
        w_any = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[wrap_idx(r_ptr, k)])
                w_idx = wrap_idx(r_ptr, k);
        end
        if (r_state == S_RUN && |req) begin
            w_any = 1'b1;
            gnt   = NREQ'(1) << w_idx;
        end
    end

    assign w_pass = (er[w_idx*WORD +: WORD] == ar[w_idx*WORD +: WORD]) &&
                    (er_bits[w_idx*BITS_W +: BITS_W] == ar_bits[w_idx*BITS_W +: BITS_W]);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= IDX_W'(NREQ - 1);
            r_step     <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_res_step <= '0;
            r_valid    <= 1'b0;
            r_pass     <= 1'b0;
            r_src      <= '0;
        end else begin
            r_valid <= w_any;
            if (w_clear) begin
                r_step     <= '0;
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
            end else if (w_any) begin
                r_step <= r_step + CNT_W'(1);
                if (w_pass) begin
                    if (r_pass_cnt != '1)
                        r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                end else begin
                    if (r_fail_cnt != '1)
                        r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                end
            end
            if (w_any) begin
                r_ptr      <= w_idx;
                r_pass     <= w_pass;
                r_src      <= 3'(w_idx);
                r_res_step <= r_step;
            end
        end
    end

    assign result_valid = r_valid;
    assign result_pass  = r_pass;
    assign result_src   = r_src;
    assign result_step  = r_res_step;
    assign pass_count   = r_pass_cnt;
    assign fail_count   = r_fail_cnt;

endmodule

// File: doc/check_scheduler.md
CHECK_SCHEDULER -- requirements
Module: check_scheduler

Interface
REQ-001 The block SHALL have the parameter WORD, default 64, meaning the width of the expected and actual result words.
REQ-002 The block SHALL have the parameter NREQ, default 4, meaning the number of requesters; the legal range is 2..8.
REQ-003 The block SHALL have the parameter BITS_W, default 7, meaning the width of each er_bits/ar_bits field.
REQ-004 The block SHALL have the parameter CNT_W, default 16, meaning the width of the step, pass and fail counters.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: clk (input, 1 bit, clock) and rst (input, 1 bit, async active-high reset).
REQ-006 The block SHALL provide the following ports:
- start  in  1  pulse; begin test
- finish  in  1  pulse; end test
- req  in  NREQ  per-requester check request
- er  in  NREQ*WORD  expected result, slice i belongs to requester i
- ar  in  NREQ*WORD  actual result, slice i
- er_bits  in  NREQ*BITS_W  expected width, slice i
- ar_bits  in  NREQ*BITS_W  actual width, slice i
- gnt  out  NREQ  one-hot accept, one cycle
- result_valid  out  1  registered compare result is valid
- result_pass  out  1  1 = pass, 0 = fail
- result_src  out  3  index of the granted requester
- result_step  out  CNT_W  step number of this result
- pass_count  out  CNT_W  running pass total
- fail_count  out  CNT_W  running fail total
- busy  out  1  FSM is in RUN
- done  out  1  FSM is in DONE

Function
REQ-007 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-008 IDLE transitions:
- start=1: go to RUN; clear pass_count, fail_count and the step counter.
- start has priority over finish.
REQ-009 RUN transitions: finish=1 goes to DONE; start is ignored.
REQ-010 DONE transitions: start=1 goes to RUN with the same clearing as in IDLE; finish is ignored.
REQ-011 gnt SHALL be all-zero in IDLE and DONE; req SHALL be ignored in those states.
REQ-012 In RUN, with any req bit set, exactly one gnt bit SHALL assert in the same cycle (combinational), selected round-robin.
REQ-013 Round-robin priority: the highest-priority requester SHALL be the one after the last granted index, wrapping from NREQ-1 to 0; the pointer SHALL update only on a grant.
REQ-014 A requester SHALL hold req and its data stable until gnt; gnt SHALL mean the check is accepted.
REQ-015 A requester that still holds req the cycle after its gnt SHALL be treated as a new check.
REQ-016 The comparison SHALL be: pass = (er_i == ar_i) && (er_bits_i == ar_bits_i), a full-width unsigned equality.
REQ-017 Results SHALL have a latency of 1 cycle:
- The cycle after a grant: result_valid=1, with result_pass, result_src and result_step registered.
- result_valid=0 otherwise.
REQ-018 result_step SHALL equal the step counter value at grant time; the first check after start is step 0; the counter increments by 1 per grant.
REQ-019 pass_count or fail_count SHALL increment in the same edge that registers the result; pass_count + fail_count SHALL equal the number of grants.
REQ-020 The counters SHALL saturate at 2^CNT_W-1 (no wrap); the step counter SHALL wrap modulo 2^CNT_W.
REQ-021 A grant in the same cycle as finish SHALL still be processed: its result appears in the next cycle (state DONE) and is counted.
REQ-022 In DONE, pass_count and fail_count SHALL hold until the next start.
REQ-023 busy SHALL be 1 iff the state is RUN; done SHALL be 1 iff the state is DONE; both SHALL be registered state decodes.

Reset
REQ-024 Asserting rst at any time, including mid-RUN, SHALL immediately apply the following:
- state = IDLE, RR pointer = NREQ-1 (requester 0 first)
- gnt = 0, result_valid = 0, result_pass = 0
- result_src = 0, result_step = 0
- pass_count = 0, fail_count = 0, step counter = 0
- busy = 0, done = 0
REQ-025 An in-flight result SHALL be discarded on reset.

Verification
REQ-026 Basic pass: start; req[0] with er=ar=0x1234, bits 16/16 -> gnt[0] in that cycle; next cycle result_valid=1, pass=1, src=0, step=0; pass_count=1.
REQ-027 Bits mismatch: er=ar=5, er_bits=8, ar_bits=16 -> result_pass=0, fail_count=1, pass_count unchanged.
REQ-028 Round-robin: req=4'b1111 held 4 cycles from reset -> gnt sequence 0001, 0010, 0100, 1000; steps 0..3.
REQ-029 Finish coincident with a grant -> done=1 next cycle; that result is valid and counted; later req in DONE gets no gnt.
REQ-030 Reset mid-RUN after 3 checks -> all outputs are at reset values; a new start begins at step 0 with zero counts.
REQ-031 Saturation with CNT_W=2: 5 passing checks -> pass_count stays 3; result_step wraps 0,1,2,3,0.
